// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store codes and FSM state type for the MEM-stage sequencer
//
// Purpose: decoder code points for loads (ResultSrc) and store sizes (StoreSrc),
// the sequencer state enum, and a helper that recognises load codes.
// Ports: none (package).
package lsu_pkg;

  localparam logic [2:0] RS_LB  = 3'b010;
  localparam logic [2:0] RS_LH  = 3'b011;
  localparam logic [2:0] RS_LW  = 3'b100;
  localparam logic [2:0] RS_LBU = 3'b101;
  localparam logic [2:0] RS_LHU = 3'b110;

  // Store size codes; also reused as the access-size encoding for loads.
  localparam logic [1:0] SS_SB = 2'b00;
  localparam logic [1:0] SS_SH = 2'b01;
  localparam logic [1:0] SS_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_load_code(input logic [2:0] rs);
    return (rs >= RS_LB) && (rs <= RS_LHU);
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load data lane extraction and sign/zero extension
//
// Purpose: picks the byte or halfword addressed by off_i out of the bus word
// and extends it according to the load type.
// Ports:
//   rdata_i      [31:0] read word from the data bus
//   off_i        [1:0]  byte offset of the load address
//   result_src_i [2:0]  load code (lb/lh/lw/lbu/lhu)
//   result_o     [31:0] extended load value
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  result_src_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (result_src_i)
      RS_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      RS_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      RS_LBU:  result_o = {24'd0, byte_sel};
      RS_LHU:  result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer on a req/ack data bus
//
// Purpose: runs one load or store at a time, stalls the pipeline until it
// completes, checks alignment, generates byte enables / lane-replicated store
// data and returns extended load data.
// Optional feature: MEM_ACCESS_TIMEOUT_EN adds a bus watchdog of TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   mem_valid_i, result_src_i,
//   mem_write_i, store_src_i       decoded memory controls
//   flush_i                        squash the MEM-stage instruction
//   addr_i, wdata_i                byte address, store data
//   stall_o                        pipeline freeze
//   ld_data_o, ld_valid_o          load result and its one-cycle valid
//   fault_o                        one-cycle fault pulse
//   bus_req_o, bus_we_o, bus_addr_o,
//   bus_be_o, bus_wdata_o          data-bus request side
//   bus_ack_i, bus_err_i,
//   bus_rdata_i                    data-bus response side
module mem_access_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic [2:0]  result_src_i,
  input  logic        mem_write_i,
  input  logic [1:0]  store_src_i,
  input  logic        flush_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  rs_q, rs_d;
  logic [1:0]  off_q, off_d;
  logic        is_ld_q, is_ld_d;
  logic        flush_q, flush_d;     // flush seen while the bus access was in flight
  logic        ld_valid_q, ld_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        access;
  logic [1:0]  size;
  logic        misalign;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] aligned;
  logic        flush_seen;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign access  = mem_valid_i & (is_load_code(result_src_i) | mem_write_i);
  assign stall_o = access & ~flush_i & (state_q != DONE);

  load_align u_load_align (
    .rdata_i      (bus_rdata_i),
    .off_i        (off_q),
    .result_src_i (rs_q),
    .result_o     (aligned)
  );

  // Access size: loads derive it from the load code, stores use StoreSrc.
  always_comb begin
    case (result_src_i)
      RS_LB, RS_LBU: size = SS_SB;
      RS_LH, RS_LHU: size = SS_SH;
      default:       size = SS_SW;
    endcase
    if (mem_write_i) size = store_src_i;

    case (size)
      SS_SB: begin
        misalign  = 1'b0;
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      SS_SH: begin
        misalign  = addr_i[0];
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      SS_SW: begin
        misalign  = |addr_i[1:0];
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
      default: begin
        misalign  = 1'b1;
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
    if (!mem_write_i) begin
      be_new    = 4'b1111;
      wdata_new = 32'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rs_d       = rs_q;
    off_d      = off_q;
    is_ld_d    = is_ld_q;
    flush_d    = flush_q;
    ld_valid_d = 1'b0;
    fault_d    = 1'b0;
    ld_data_d  = ld_data_q;
    flush_seen = flush_q | flush_i;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (access && !flush_i) begin
          if (misalign) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = mem_write_i;
            addr_d  = {addr_i[31:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
            rs_d    = result_src_i;
            off_d   = addr_i[1:0];
            is_ld_d = ~mem_write_i;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      REQ: begin
        flush_d = flush_seen;
        // Error takes priority over a simultaneous ack.
        if (bus_err_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          fault_d = ~flush_seen;
        end else if (bus_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (is_ld_q && !flush_seen) begin
            ld_valid_d = 1'b1;
            ld_data_d  = aligned;
          end
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          fault_d = ~flush_seen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rs_q       <= 3'd0;
      off_q      <= 2'd0;
      is_ld_q    <= 1'b0;
      flush_q    <= 1'b0;
      ld_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      ld_data_q  <= 32'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rs_q       <= rs_d;
      off_q      <= off_d;
      is_ld_q    <= is_ld_d;
      flush_q    <= flush_d;
      ld_valid_q <= ld_valid_d;
      fault_q    <= fault_d;
      ld_data_q  <= ld_data_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign ld_valid_o  = ld_valid_q;
  assign fault_o     = fault_q;
  assign ld_data_o   = ld_data_q;

endmodule
